deferred_step_batcher: RTL and testbench

- Upstream feeder of the deferred-result step controller: batches DUT clock advances into multi-cycle step counts for the host-side simv_nstep call.
- Emits `step` as a one-cycle nonzero pulse when one of these occurs:
  - the batch fills;
  - an idle timeout expires;
  - an explicit flush arrives.
- Stops emitting permanently once the deferred result is raised, so the host is never stepped past a reported failure.

---
 rtl/difftest_step_pkg.sv | 21 ++
 rtl/deferred_step_counter.sv | 35 +++
 rtl/deferred_step_batcher.sv | 115 +++++++++++
 tb/tb_deferred_step_batcher.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/difftest_step_pkg.sv
// Shared definitions for the deferred step batcher.
//   state_e      : batcher state (ACCUM collects cycles, HALT stops emission)
//   STEP_WIDTH_DEF: default width of the step count
//   timer_width(): bits needed to hold an idle timer value of TIMEOUT-1
package difftest_step_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HALT  = 1'b1
  } state_e;

  localparam int STEP_WIDTH_DEF = 8;

  // clog2(TIMEOUT) bits, never less than 1 (TIMEOUT=1 still needs a flop).
  function automatic int timer_width(input int timeout);
    int w;
    w = $clog2(timeout);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/deferred_step_counter.sv
// Generic clearable up-counter.
//   clock, reset : clock and synchronous active-high reset
//   clr          : clear to zero (wins over en)
//   en           : increment by one
//   count        : registered count
// SATURATE=1 holds at all-ones, SATURATE=0 wraps.
module deferred_step_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en && !(SATURATE && (count_q == {WIDTH{1'b1}})))
      count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/deferred_step_batcher.sv
// Batches DUT clock advances into multi-cycle step counts for the host.
//   clock, reset  : clock, synchronous active-high reset
//   cycle_en      : DUT advanced one cycle this clock
//   flush         : emit any pending partial batch now
//   simv_result   : deferred failure raised downstream; halts emission forever
//   step          : one-cycle nonzero pulse carrying the emitted count
//   pending       : accumulated, not-yet-emitted count
//   halted        : block is in HALT
//   dropped       : saturating count of cycle_en seen while halted
//   total_steps   : wrapping sum of all emitted steps
module deferred_step_batcher
  import difftest_step_pkg::*;
#(
  parameter int STEP_WIDTH = STEP_WIDTH_DEF,
  parameter int BATCH      = 64,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cycle_en,
  input  logic                  flush,
  input  logic                  simv_result,
  output logic [STEP_WIDTH-1:0] step,
  output logic [STEP_WIDTH-1:0] pending,
  output logic                  halted,
  output logic [15:0]           dropped,
  output logic [63:0]           total_steps
);

  localparam int TW = timer_width(TIMEOUT);

  state_e                state_d, state_q;
  logic [STEP_WIDTH-1:0] step_d, step_q;
  logic [63:0]           total_d, total_q;
  logic [STEP_WIDTH-1:0] acc;
  logic [TW-1:0]         timer;
  logic [STEP_WIDTH-1:0] acc_next;
  logic                  acc_nz, emit;
  logic                  acc_clr, acc_inc, tmr_clr, tmr_inc, drop_inc;

  deferred_step_counter #(.WIDTH(STEP_WIDTH), .SATURATE(1'b0)) u_acc (
    .clock(clock), .reset(reset), .clr(acc_clr), .en(acc_inc), .count(acc)
  );

  deferred_step_counter #(.WIDTH(TW), .SATURATE(1'b0)) u_timer (
    .clock(clock), .reset(reset), .clr(tmr_clr), .en(tmr_inc), .count(timer)
  );

  deferred_step_counter #(.WIDTH(16), .SATURATE(1'b1)) u_dropped (
    .clock(clock), .reset(reset), .clr(1'b0), .en(drop_inc), .count(dropped)
  );

  always_comb begin
    // The emitting cycle's own cycle_en is part of the emitted count.
    acc_next = acc + STEP_WIDTH'(cycle_en);
    acc_nz   = (acc_next != '0);
    state_d  = state_q;
    step_d   = '0;
    total_d  = total_q;
    emit     = 1'b0;
    acc_clr  = 1'b0;
    acc_inc  = 1'b0;
    tmr_clr  = 1'b0;
    tmr_inc  = 1'b0;
    drop_inc = 1'b0;
    case (state_q)
      ACCUM: begin
        if (simv_result) begin
          // Failure outranks any emission this cycle; pending work is discarded.
          state_d = HALT;
          acc_clr = 1'b1;
          tmr_clr = 1'b1;
        end else begin
          emit = (acc_next == STEP_WIDTH'(BATCH))
               | (flush & acc_nz)
               | ((timer == TW'(TIMEOUT - 1)) & acc_nz);
          if (emit) begin
            step_d  = acc_next;
            total_d = total_q + 64'(acc_next);
            acc_clr = 1'b1;
            tmr_clr = 1'b1;
          end else begin
            acc_inc = cycle_en;
            tmr_inc = acc_nz;
            tmr_clr = !acc_nz;
          end
        end
      end
      HALT: begin
        acc_clr  = 1'b1;
        tmr_clr  = 1'b1;
        drop_inc = cycle_en;
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ACCUM;
      step_q  <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      total_q <= total_d;
    end
  end

  assign step        = step_q;
  assign pending     = acc;
  assign halted      = (state_q == HALT);
  assign total_steps = total_q;

endmodule

// File: tb/tb_deferred_step_batcher.sv
module tb_deferred_step_batcher;

  localparam int N = 4;
  localparam int BAT [N] = '{4, 64, 1, 64};
  localparam int TMO [N] = '{256, 8, 256, 256};

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cycle_en = 1'b0, flush = 1'b0, simv_result = 1'b0;

  logic [7:0]  step_o [N];
  logic [7:0]  pend_o [N];
  logic        halt_o [N];
  logic [15:0] drop_o [N];
  logic [63:0] tot_o  [N];

  int checks = 0;
  int errors = 0;

  // Reference state, one entry per instance.
  int          m_acc  [N];
  int          m_idle [N];
  int          m_step [N];
  bit          m_halt [N];
  logic [15:0] m_drop [N];
  logic [63:0] m_tot  [N];

  always #5 clock = ~clock;

  for (genvar g = 0; g < N; g++) begin : g_dut
    deferred_step_batcher #(.STEP_WIDTH(8), .BATCH(BAT[g]), .TIMEOUT(TMO[g])) u_dut (
      .clock(clock), .reset(reset), .cycle_en(cycle_en), .flush(flush),
      .simv_result(simv_result), .step(step_o[g]), .pending(pend_o[g]),
      .halted(halt_o[g]), .dropped(drop_o[g]), .total_steps(tot_o[g])
    );
  end

  // Apply one clock of inputs, advance the reference, sample 1 time unit after the edge.
  task automatic cycle(input bit en, input bit fl, input bit res, input bit rst);
    int  an;
    bit  e;
    cycle_en = en; flush = fl; simv_result = res; reset = rst;
    @(posedge clock);
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_acc[i] = 0; m_idle[i] = 0; m_step[i] = 0; m_halt[i] = 0;
        m_drop[i] = '0; m_tot[i] = '0;
      end else if (m_halt[i]) begin
        m_step[i] = 0;
        if (en && m_drop[i] != 16'hFFFF) m_drop[i] = m_drop[i] + 16'd1;
      end else if (res) begin
        m_halt[i] = 1; m_step[i] = 0; m_acc[i] = 0; m_idle[i] = 0;
      end else begin
        an = m_acc[i] + int'(en);
        e  = (an == BAT[i]) || (fl && an != 0) || (m_idle[i] == TMO[i] - 1 && an != 0);
        if (e) begin
          m_step[i] = an; m_acc[i] = 0; m_idle[i] = 0;
          m_tot[i]  = m_tot[i] + 64'(an);
        end else begin
          m_step[i] = 0; m_acc[i] = an;
          m_idle[i] = (an != 0) ? m_idle[i] + 1 : 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(0, 0, 0, 1);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (step_o[i] !== 8'd0 || pend_o[i] !== 8'd0 || halt_o[i] !== 1'b0 ||
          drop_o[i] !== 16'd0 || tot_o[i] !== 64'd0) begin
        errors++;
        $display("FAIL reset inst%0d: got step=%0d pend=%0d halt=%0b drop=%0d tot=%0d want all 0",
                 i, step_o[i], pend_o[i], halt_o[i], drop_o[i], tot_o[i]);
      end
    end
  endtask

  task automatic test_batch();
    cycle(0, 0, 0, 1);
    for (int k = 1; k <= 8; k++) begin
      cycle(1, 0, 0, 0);
      checks++;
      if (step_o[0] !== ((k % 4 == 0) ? 8'd4 : 8'd0) || pend_o[0] !== 8'(k % 4)) begin
        errors++;
        $display("FAIL batch4 cycle%0d: got step=%0d pend=%0d want step=%0d pend=%0d",
                 k, step_o[0], pend_o[0], (k % 4 == 0) ? 4 : 0, k % 4);
      end
      checks++;
      if (step_o[2] !== 8'd1 || pend_o[2] !== 8'd0) begin
        errors++;
        $display("FAIL batch1 cycle%0d: got step=%0d pend=%0d want step=1 pend=0",
                 k, step_o[2], pend_o[2]);
      end
    end
    checks++;
    if (tot_o[0] !== 64'd8 || tot_o[2] !== 64'd8) begin
      errors++;
      $display("FAIL batch_total: got %0d/%0d want 8/8", tot_o[0], tot_o[2]);
    end
  endtask

  task automatic test_flush();
    cycle(0, 0, 0, 1);
    repeat (5) cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    checks++;
    if (step_o[3] !== 8'd6 || pend_o[3] !== 8'd0) begin
      errors++;
      $display("FAIL flush_emit: got step=%0d pend=%0d want step=6 pend=0", step_o[3], pend_o[3]);
    end
    cycle(0, 1, 0, 0);
    checks++;
    if (step_o[3] !== 8'd0 || tot_o[3] !== 64'd6) begin
      errors++;
      $display("FAIL flush_empty: got step=%0d tot=%0d want step=0 tot=6", step_o[3], tot_o[3]);
    end
  endtask

  task automatic test_timeout();
    cycle(0, 0, 0, 1);
    // 3 enables then idle: timer reaches 7 in cycle 8, so step appears after edge 8.
    for (int k = 1; k <= 20; k++) begin
      cycle(k <= 3, 0, 0, 0);
      checks++;
      if (step_o[1] !== ((k == 8) ? 8'd3 : 8'd0)) begin
        errors++;
        $display("FAIL timeout cycle%0d: got step=%0d want %0d", k, step_o[1], (k == 8) ? 3 : 0);
      end
      checks++;
      if (step_o[3] !== 8'd0 || pend_o[3] !== 8'((k <= 3) ? k : 3)) begin
        errors++;
        $display("FAIL no_timeout cycle%0d: got step=%0d pend=%0d want step=0 pend=%0d",
                 k, step_o[3], pend_o[3], (k <= 3) ? k : 3);
      end
    end
  endtask

  task automatic test_halt();
    cycle(0, 0, 0, 1);
    repeat (10) cycle(1, 0, 0, 0);
    checks++;
    if (pend_o[3] !== 8'd10) begin
      errors++;
      $display("FAIL halt_pending: got %0d want 10", pend_o[3]);
    end
    cycle(0, 1, 1, 0);
    checks++;
    if (step_o[3] !== 8'd0 || halt_o[3] !== 1'b1 || pend_o[3] !== 8'd0 || tot_o[3] !== 64'd0) begin
      errors++;
      $display("FAIL halt_entry: got step=%0d halt=%0b pend=%0d tot=%0d want 0/1/0/0",
               step_o[3], halt_o[3], pend_o[3], tot_o[3]);
    end
    for (int k = 1; k <= 20; k++) begin
      cycle(1, k[0], 1, 0);
      checks++;
      if (step_o[3] !== 8'd0 || step_o[2] !== 8'd0) begin
        errors++;
        $display("FAIL halt_step cycle%0d: got %0d/%0d want 0", k, step_o[3], step_o[2]);
      end
    end
    checks++;
    if (drop_o[3] !== 16'd20 || pend_o[3] !== 8'd0) begin
      errors++;
      $display("FAIL halt_dropped: got drop=%0d pend=%0d want 20/0", drop_o[3], pend_o[3]);
    end
  endtask

  task automatic test_reset_mid();
    cycle(0, 0, 0, 1);
    repeat (30) cycle(1, 0, 0, 0);
    checks++;
    if (pend_o[3] !== 8'd30) begin
      errors++;
      $display("FAIL mid_pending: got %0d want 30", pend_o[3]);
    end
    cycle(1, 1, 0, 1);
    checks++;
    if (step_o[3] !== 8'd0 || pend_o[3] !== 8'd0 || halt_o[3] !== 1'b0 || tot_o[3] !== 64'd0 ||
        tot_o[0] !== 64'd0 || step_o[2] !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: got step=%0d pend=%0d halt=%0b tot=%0d totA=%0d want all 0",
               step_o[3], pend_o[3], halt_o[3], tot_o[3], tot_o[0]);
    end
    for (int k = 1; k <= 4; k++) begin
      cycle(1, 0, 0, 0);
      checks++;
      if (step_o[0] !== ((k == 4) ? 8'd4 : 8'd0) || pend_o[3] !== 8'(k)) begin
        errors++;
        $display("FAIL mid_restart cycle%0d: got stepA=%0d pendD=%0d want %0d/%0d",
                 k, step_o[0], pend_o[3], (k == 4) ? 4 : 0, k);
      end
    end
  endtask

  task automatic test_random();
    bit rst_r, res_r;
    cycle(0, 0, 0, 1);
    res_r = 0;
    for (int k = 0; k < 3000; k++) begin
      rst_r = ($urandom_range(999) < 4);
      if (rst_r) res_r = 0;
      else if ($urandom_range(999) < 3) res_r = 1;
      cycle($urandom_range(99) < 70, $urandom_range(99) < 5, res_r, rst_r);
      for (int i = 0; i < N; i++) begin
        checks++;
        if (step_o[i] !== 8'(m_step[i]) || pend_o[i] !== 8'(m_acc[i]) || halt_o[i] !== m_halt[i] ||
            drop_o[i] !== m_drop[i] || tot_o[i] !== m_tot[i]) begin
          errors++;
          $display("FAIL random c%0d inst%0d: got step=%0d pend=%0d halt=%0b drop=%0d tot=%0d want %0d/%0d/%0b/%0d/%0d",
                   k, i, step_o[i], pend_o[i], halt_o[i], drop_o[i], tot_o[i],
                   m_step[i], m_acc[i], m_halt[i], m_drop[i], m_tot[i]);
        end
      end
    end
  endtask

  task automatic test_saturate();
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
    repeat (70000) cycle(1, 0, 1, 0);
    checks++;
    if (drop_o[0] !== 16'hFFFF || drop_o[3] !== 16'hFFFF || step_o[2] !== 8'd0) begin
      errors++;
      $display("FAIL saturate: got drop=%0h/%0h step=%0d want ffff/ffff step=0",
               drop_o[0], drop_o[3], step_o[2]);
    end
  endtask

  initial begin
    test_reset();
    test_batch();
    test_flush();
    test_timeout();
    test_halt();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
